hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage RV32I core. Every cycle it generates the stall and flush (CLR) controls for the F/D, D/E, E/M and M/W pipeline registers, and the operand forwarding selects for the execute stage. It handles three cases: load-use hazards, taken branches and jumps, and multi-cycle data-memory waits. It also keeps a memory-wait watchdog and saturating stall and flush performance counters.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

  // Execute-stage ALU operand source
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Memory-wait sequencer states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one Execute-stage operand.
// Memory stage has priority over Writeback, and x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic [ADDRESS_WIDTH-1:0] rs,
  input  logic [ADDRESS_WIDTH-1:0] rd_m,
  input  logic [ADDRESS_WIDTH-1:0] rd_w,
  input  logic                     reg_write_m,
  input  logic                     reg_write_w,
  output fwd_sel_t                 sel
);

  // Pick the youngest in-flight producer of rs
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      sel = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush generation, forwarding selects,
// memory-wait watchdog and saturating performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [ADDRESS_WIDTH-1:0] RdE,
  input  logic [ADDRESS_WIDTH-1:0] RdM,
  input  logic [ADDRESS_WIDTH-1:0] RdW,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     MemReadE,
  input  logic                     PCSrcE,
  input  logic                     DMemReqM,
  input  logic                     DMemReadyM,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     StallM,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushW,
  output fwd_sel_t                 ForwardAE,
  output fwd_sel_t                 ForwardBE,
  output logic                     MemTimeout,
  output logic [CNT_WIDTH-1:0]     StallCycles,
  output logic [CNT_WIDTH-1:0]     FlushCount
);

  localparam int unsigned WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(TIMEOUT);

  hz_state_t      state;
  logic [WCW-1:0] wait_cnt;
  logic           lw_stall;
  logic           mem_stall;

  fwd_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
    .rs          (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardAE)
  );

  fwd_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
    .rs          (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardBE)
  );

  assign lw_stall  = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = DMemReqM && !DMemReadyM;

  // Prioritised stall/flush decode; a taken branch during a memory wait is
  // held in the frozen E stage and resolves again on the release cycle
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (RST) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Memory-wait sequencer with sticky watchdog
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (DMemReadyM || !DMemReqM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            MemTimeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating stall and flush performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != '1))
        StallCycles <= StallCycles + CNT_WIDTH'(1);
      if (PCSrcE && !mem_stall && (FlushCount != '1))
        FlushCount <= FlushCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (CNT_WIDTH=4, TIMEOUT=4).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       CLK;
  logic       RST;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, DMemReqM, DMemReadyM;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  fwd_sel_t   ForwardAE, ForwardBE;
  logic       MemTimeout;
  logic [3:0] StallCycles, FlushCount;

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.ADDRESS_WIDTH(5), .CNT_WIDTH(4), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then move 1 time unit past it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReadE = 1'b0; PCSrcE = 1'b0;
    DMemReqM = 1'b0; DMemReadyM = 1'b0;

    // reset
    tick(); tick();
    chk("rst_flushD", FlushD, 1);
    chk("rst_flushE", FlushE, 1);
    chk("rst_flushW", FlushW, 1);
    chk("rst_stallF", StallF, 0);
    chk("rst_stallCycles", StallCycles, 0);
    chk("rst_flushCount", FlushCount, 0);
    chk("rst_memTimeout", MemTimeout, 0);
    RST = 1'b0;
    #1;
    chk("idle_flushD", FlushD, 0);
    chk("idle_stallF", StallF, 0);

    // forwarding
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; #1;
    chk("fwdA_mem", ForwardAE, 2'b10);
    chk("fwdB_rf", ForwardBE, 2'b00);
    RdM = 0; #1;
    chk("fwdA_wb", ForwardAE, 2'b01);
    RegWriteW = 0; #1;
    chk("fwdA_none", ForwardAE, 2'b00);
    RdM = 3; RegWriteM = 1; RdW = 9; RegWriteW = 1; Rs2E = 9; Rs1E = 3; #1;
    chk("fwdB_wb", ForwardBE, 2'b01);
    chk("fwdA_mem2", ForwardAE, 2'b10);
    Rs2E = 0; RdW = 0; #1;
    chk("fwdB_x0", ForwardBE, 2'b00);
    Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 0; RegWriteW = 0;

    // load-use: one bubble
    tick();
    MemReadE = 1; RdE = 7; Rs2D = 7; #1;
    chk("lw_stallF", StallF, 1);
    chk("lw_stallD", StallD, 1);
    chk("lw_flushE", FlushE, 1);
    chk("lw_flushD", FlushD, 0);
    chk("lw_stallE", StallE, 0);
    tick();
    MemReadE = 0; #1;
    chk("lw_next_stallF", StallF, 0);
    chk("lw_next_flushE", FlushE, 0);
    chk("lw_stallCycles", StallCycles, 1);

    // taken branch with load-use suppressed
    PCSrcE = 1; MemReadE = 1; #1;
    chk("br_flushD", FlushD, 1);
    chk("br_flushE", FlushE, 1);
    chk("br_stallF", StallF, 0);
    chk("br_stallD", StallD, 0);
    tick();
    PCSrcE = 0; MemReadE = 0; RdE = 0; Rs2D = 0; #1;
    chk("br_flushCount", FlushCount, 1);
    chk("br_stallCycles", StallCycles, 1);

    // three-cycle memory wait with a branch deferred behind it
    DMemReqM = 1; DMemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_stallF", StallF, 1);
      chk("mw_stallM", StallM, 1);
      chk("mw_flushW", FlushW, 1);
      chk("mw_flushD", FlushD, 0);
      tick();
    end
    chk("mw_flushCount_held", FlushCount, 1);
    DMemReadyM = 1; #1;
    chk("mw_rel_stallF", StallF, 0);
    chk("mw_rel_flushW", FlushW, 0);
    chk("mw_rel_flushD", FlushD, 1);
    tick();
    DMemReqM = 0; DMemReadyM = 0; PCSrcE = 0; #1;
    chk("mw_stallCycles", StallCycles, 4);
    chk("mw_flushCount", FlushCount, 2);
    chk("mw_memTimeout", MemTimeout, 0);

    // watchdog: timeout raised on the 5th stalled edge, then sticky
    DMemReqM = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("wd_before", MemTimeout, 0);
    tick();
    chk("wd_raised", MemTimeout, 1);
    DMemReqM = 0;
    tick();
    chk("wd_sticky", MemTimeout, 1);
    chk("wd_stallCycles", StallCycles, 9);

    // reset in the middle of a wait
    DMemReqM = 1; tick(); tick();
    RST = 1; #1;
    chk("rstw_flushD", FlushD, 1);
    chk("rstw_stallF", StallF, 0);
    tick();
    RST = 0; #1;
    chk("rstw_memTimeout", MemTimeout, 0);
    chk("rstw_stallCycles", StallCycles, 0);
    chk("rstw_flushCount", FlushCount, 0);
    // fresh wait from RUN must again time out on exactly the 5th edge
    for (int i = 0; i < 4; i++) tick();
    chk("rstw_wd_before", MemTimeout, 0);
    tick();
    chk("rstw_wd_raised", MemTimeout, 1);

    // stall counter saturation
    RST = 1; tick(); RST = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", StallCycles, 14);
    tick();
    chk("sat_15", StallCycles, 15);
    tick();
    chk("sat_hold", StallCycles, 15);
    DMemReqM = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
